// File: rtl/synverll_sdiv_caller.sv
// rtl/synverll_sdiv_caller.sv - credit-flow initiator for a fixed-latency pipelined sdiv callee
// Optional divide-by-zero override enabled by SYNVERLL_SDIV_CALLER_DBZ_EN.
module synverll_sdiv_caller #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        __call_sdiv_req,
  input  logic        __call_sdiv_ready,
  output logic [31:0] __call_sdiv_args_0,
  output logic [31:0] __call_sdiv_args_1,
  input  logic        __call_sdiv_done,
  input  logic [31:0] __call_sdiv_q,
  input  logic [31:0] __call_sdiv_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [31:0] out_r,
  output logic        out_dbz,
  output logic        err_protocol
);

  localparam logic [FIFO_AW:0] LP_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [FIFO_AW:0]   r_credits;
  logic [FIFO_AW:0]   r_outstanding;
  logic [FIFO_AW:0]   r_count;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic               r_req;
  logic [31:0]        r_arg0;
  logic [31:0]        r_arg1;
  logic               r_err;
  logic [31:0]        r_mem_q [FIFO_DEPTH];
  logic [31:0]        r_mem_r [FIFO_DEPTH];

  logic        w_issue;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_capture;
  logic        w_push;
  logic        w_err_evt;
  logic [31:0] w_push_q;
  logic [31:0] w_push_r;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign in_ready  = (r_credits != '0) & __call_sdiv_ready;
  assign w_issue   = in_valid & in_ready;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  // A done with nothing outstanding carries no valid result, so it is flagged and dropped.
  assign w_capture = __call_sdiv_done & (r_outstanding != '0);
  assign w_push    = w_capture & ~w_full;
  assign w_err_evt = __call_sdiv_done & ((r_outstanding == '0) | w_full);

  assign __call_sdiv_req    = r_req;
  assign __call_sdiv_args_0 = r_arg0;
  assign __call_sdiv_args_1 = r_arg1;
  assign err_protocol       = r_err;
  assign out_q              = w_empty ? '0 : r_mem_q[r_rd_ptr];
  assign out_r              = w_empty ? '0 : r_mem_r[r_rd_ptr];

`ifdef SYNVERLL_SDIV_CALLER_DBZ_EN
  logic               r_dbz_flag [FIFO_DEPTH];
  logic [31:0]        r_dbz_num  [FIFO_DEPTH];
  logic               r_mem_dbz  [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_fq_wr;
  logic [FIFO_AW-1:0] r_fq_rd;
  logic               w_flag;
  logic [31:0]        w_num;

  // Flag queue tracks the same calls as the callee pipeline, so capture order matches issue order.
  assign w_flag   = r_dbz_flag[r_fq_rd];
  assign w_num    = r_dbz_num[r_fq_rd];
  assign w_push_q = w_flag ? (w_num[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : __call_sdiv_q;
  assign w_push_r = w_flag ? w_num : __call_sdiv_r;
  assign out_dbz  = w_empty ? 1'b0 : r_mem_dbz[r_rd_ptr];

  always_ff @(posedge system_clock or negedge system_reset) begin
    if (!system_reset) begin
      r_fq_wr <= '0;
      r_fq_rd <= '0;
    end else begin
      if (w_issue)   r_fq_wr <= r_fq_wr + 1'b1;
      if (w_capture) r_fq_rd <= r_fq_rd + 1'b1;
    end
  end

  always_ff @(posedge system_clock) begin
    if (w_issue) begin
      r_dbz_flag[r_fq_wr] <= (in_divisor == '0);
      r_dbz_num[r_fq_wr]  <= in_dividend;
    end
    if (w_push) r_mem_dbz[r_wr_ptr] <= w_flag;
  end
`else
  assign w_push_q = __call_sdiv_q;
  assign w_push_r = __call_sdiv_r;
  assign out_dbz  = 1'b0;
`endif

  always_ff @(posedge system_clock or negedge system_reset) begin
    if (!system_reset) begin
      r_req         <= 1'b0;
      r_arg0        <= '0;
      r_arg1        <= '0;
      r_credits     <= LP_DEPTH;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_req <= w_issue;
      if (w_issue) begin
        r_arg0 <= in_dividend;
        r_arg1 <= in_divisor;
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   if (r_credits != LP_DEPTH) r_credits <= r_credits + 1'b1;
        default: ;
      endcase
      case ({w_issue, w_capture})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: ;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_err_evt) r_err    <= 1'b1;
    end
  end

  always_ff @(posedge system_clock) begin
    if (w_push) begin
      r_mem_q[r_wr_ptr] <= w_push_q;
      r_mem_r[r_wr_ptr] <= w_push_r;
    end
  end

endmodule
